// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: stall bus type,
// Stop/NoStop encodings, the two stall patterns and the divide FSM states.
package pipe_ctrl_pkg;

  localparam int unsigned STALL_W = 6;
  localparam int unsigned WD_W    = 6;

  // Bit order: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB
  typedef logic [STALL_W-1:0] stall_bus_t;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam stall_bus_t STALL_NONE = {STALL_W{NO_STOP}};
  localparam stall_bus_t STALL_ID   = {NO_STOP, NO_STOP, NO_STOP, STOP, STOP, STOP};
  localparam stall_bus_t STALL_EX   = {NO_STOP, NO_STOP, STOP, STOP, STOP, STOP};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/pipe_ctrl_div_watchdog.sv
// div_watchdog: 6-bit BUSY-cycle counter and timeout compare for the divider.
module div_watchdog
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam logic [WD_W-1:0] LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] count;

  // NOTE: flops use non-blocking assignments so every register samples
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: per-stage stall generation and iterative-divider handshake FSM.
// Optional build macro PIPE_CTRL_PERF_EN adds saturating stall perf counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DIV_TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_id,
  input  logic        div_req,
  input  logic        div_ready,
  output stall_bus_t  stall,
  output logic        div_start,
  output logic        div_busy,
  output logic        div_timeout
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt_id,
  output logic [31:0] stall_cnt_ex
`endif
);

  div_state_t state, state_nxt;
  logic       wd_clear, wd_inc, wd_expired, timeout_set;

  div_watchdog #(.TIMEOUT(DIV_TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .inc     (wd_inc),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    wd_clear    = 1'b0;
    wd_inc      = 1'b0;
    timeout_set = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (div_req) begin
          state_nxt = ST_BUSY;
          wd_clear  = 1'b1;
        end
      end
      ST_BUSY: begin
        // A coincident div_ready wins over the watchdog.
        if (div_ready) begin
          state_nxt = ST_DONE;
        end else if (wd_expired) begin
          state_nxt   = ST_DONE;
          timeout_set = 1'b1;
        end else begin
          wd_inc = 1'b1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  logic ex_hold;
  assign ex_hold = ((state == ST_IDLE) && div_req) || (state == ST_BUSY);

  // Outputs are held quiet while reset is asserted, whatever the inputs do.
  always_comb begin
    stall = STALL_NONE;
    if (rst) begin
      if (ex_hold)               stall = STALL_EX;
      else if (stallreq_from_id) stall = STALL_ID;
    end
  end

  assign div_start = rst && (state == ST_IDLE) && div_req;
  assign div_busy  = (state == ST_BUSY);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             div_timeout <= 1'b0;
    else if (timeout_set) div_timeout <= 1'b1;
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_id <= '0;
      stall_cnt_ex <= '0;
    end else begin
      if (stall == STALL_ID && stall_cnt_id != 32'hFFFF_FFFF)
        stall_cnt_id <= stall_cnt_id + 32'd1;
      if (stall == STALL_EX && stall_cnt_ex != 32'hFFFF_FFFF)
        stall_cnt_ex <= stall_cnt_ex + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: two instances (DIV_TIMEOUT 40 and 8) share
// reset; a transaction-level model queues per-cycle expectations for a monitor.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int T0 = 40;
  localparam int T1 = 8;

  localparam logic [5:0] P_NONE = 6'b000000;
  localparam logic [5:0] P_ID   = 6'b000111;
  localparam logic [5:0] P_EX   = 6'b001111;

  typedef struct packed {
    logic [5:0] stall;
    logic       start;
    logic       busy;
    logic       tmo;
  } exp_t;
  typedef exp_t [1:0] exp_pair_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req  [2];
  logic        id   [2];
  logic        rdy  [2];
  stall_bus_t  stall[2];
  logic        start[2];
  logic        busy [2];
  logic        tmo  [2];
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] cnt_id[2];
  logic [31:0] cnt_ex[2];
`endif

  exp_pair_t   sb[$];
  int          vectors     = 0;
  int          miscompares = 0;
  logic        mtmo  [2];
  int unsigned exp_id[2];
  int unsigned exp_ex[2];

  always #5 clk = ~clk;

  pipe_ctrl #(.DIV_TIMEOUT(T0)) dut0 (
    .clk(clk), .rst(rst), .stallreq_from_id(id[0]), .div_req(req[0]),
    .div_ready(rdy[0]), .stall(stall[0]), .div_start(start[0]),
    .div_busy(busy[0]), .div_timeout(tmo[0])
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cnt_id(cnt_id[0]), .stall_cnt_ex(cnt_ex[0])
`endif
  );

  pipe_ctrl #(.DIV_TIMEOUT(T1)) dut1 (
    .clk(clk), .rst(rst), .stallreq_from_id(id[1]), .div_req(req[1]),
    .div_ready(rdy[1]), .stall(stall[1]), .div_start(start[1]),
    .div_busy(busy[1]), .div_timeout(tmo[1])
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cnt_id(cnt_id[1]), .stall_cnt_ex(cnt_ex[1])
`endif
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, got, want, $time);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock cycle of stimulus on instance u; the other instance idles.
  task automatic drive(input int u, input logic r, input logic rq, input logic i_d,
                       input logic rd, input logic [5:0] es, input logic est,
                       input logic eb);
    exp_pair_t p;
    @(posedge clk);
    #1;
    rst = r;
    for (int k = 0; k < 2; k++) begin
      req[k] = (k == u) ? rq  : 1'b0;
      id[k]  = (k == u) ? i_d : 1'b0;
      rdy[k] = (k == u) ? rd  : 1'b0;
      if (!r) begin
        mtmo[k]   = 1'b0;
        exp_id[k] = 0;
        exp_ex[k] = 0;
        p[k]      = '0;
      end else begin
        p[k].stall = (k == u) ? es  : P_NONE;
        p[k].start = (k == u) ? est : 1'b0;
        p[k].busy  = (k == u) ? eb  : 1'b0;
        p[k].tmo   = mtmo[k];
        if (p[k].stall == P_ID) exp_id[k]++;
        if (p[k].stall == P_EX) exp_ex[k]++;
      end
    end
    sb.push_back(p);
  endtask

  // id_mode: 0 random, 1 forced high, 2 forced low
  task automatic do_idle(input int u, input int n, input int id_mode);
    logic i_d;
    for (int i = 0; i < n; i++) begin
      i_d = (id_mode == 0) ? rbit() : (id_mode == 1);
      drive(u, 1'b1, 1'b0, i_d, rbit(), i_d ? P_ID : P_NONE, 1'b0, 1'b0);
    end
  endtask

  // Divide whose div_ready arrives in BUSY cycle j (j > timeout: never).
  // mode: 0 random req/id, 1 req held with id low, 2 req and id held high.
  // rst_at > 0 drops reset in that BUSY cycle and abandons the divide.
  task automatic do_div(input int u, input int j, input int mode, input int rst_at);
    int   t;
    int   len;
    logic rq;
    logic i_d;
    t   = (u == 1) ? T1 : T0;
    len = (j <= t) ? j : t;
    i_d = (mode == 2) ? 1'b1 : (mode == 1) ? 1'b0 : rbit();
    drive(u, 1'b1, 1'b1, i_d, rbit(), P_EX, 1'b1, 1'b0);
    for (int i = 1; i <= len; i++) begin
      rq  = (mode != 0) ? 1'b1 : rbit();
      i_d = (mode == 2) ? 1'b1 : (mode == 1) ? 1'b0 : rbit();
      if (i == rst_at) begin
        drive(u, 1'b0, rq, i_d, rbit(), P_NONE, 1'b0, 1'b0);
        drive(u, 1'b0, rbit(), rbit(), rbit(), P_NONE, 1'b0, 1'b0);
        return;
      end
      drive(u, 1'b1, rq, i_d, (i == j), P_EX, 1'b0, 1'b1);
    end
    if (j > t) mtmo[u] = 1'b1;
    rq  = (mode != 0) ? 1'b1 : rbit();
    i_d = (mode == 2) ? 1'b1 : (mode == 1) ? 1'b0 : rbit();
    drive(u, 1'b1, rq, i_d, rbit(), i_d ? P_ID : P_NONE, 1'b0, 1'b0);
  endtask

  task automatic check_perf(input string tag);
`ifdef PIPE_CTRL_PERF_EN
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s dut%0d stall_cnt_id", tag, k), cnt_id[k], exp_id[k]);
      check($sformatf("%s dut%0d stall_cnt_ex", tag, k), cnt_ex[k], exp_ex[k]);
    end
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // Monitor: every cycle the outputs are live, so pop one expectation per cycle.
  initial begin
    exp_pair_t p;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        p = sb.pop_front();
        for (int k = 0; k < 2; k++) begin
          check($sformatf("dut%0d stall", k), {26'b0, stall[k]}, {26'b0, p[k].stall});
          check($sformatf("dut%0d div_start", k), {31'b0, start[k]}, {31'b0, p[k].start});
          check($sformatf("dut%0d div_busy", k), {31'b0, busy[k]}, {31'b0, p[k].busy});
          check($sformatf("dut%0d div_timeout", k), {31'b0, tmo[k]}, {31'b0, p[k].tmo});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    int u, t, op, j, guard;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; id[k] = 1'b0; rdy[k] = 1'b0;
      mtmo[k] = 1'b0; exp_id[k] = 0; exp_ex[k] = 0;
    end

    drive(0, 1'b0, 1'b1, 1'b1, 1'b0, P_NONE, 1'b0, 1'b0);
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0, P_NONE, 1'b0, 1'b0);

    do_idle(0, 1, 1);          // single load-use bubble
    do_idle(0, 2, 2);
    do_div(0, 10, 1, 0);       // ready 10 cycles after start
    do_idle(0, 2, 2);
    do_div(0, 3, 2, 0);        // div_req with stallreq_from_id
    do_idle(0, 1, 2);
    do_div(1, T1 + 5, 0, 0);   // watchdog abort on the short-timeout instance
    do_idle(1, 4, 0);
    do_div(1, T1, 0, 0);       // ready coincides with the timeout compare
    do_idle(1, 2, 0);
    do_div(0, 20, 0, 3);       // reset in BUSY cycle 3
    do_div(0, 5, 0, 0);
    do_div(0, 2, 0, 0);        // back-to-back divides
    do_div(0, 3, 0, 0);

    drive(0, 1'b0, 1'b0, 1'b0, 1'b0, P_NONE, 1'b0, 1'b0);
    do_idle(0, 5, 1);
    do_div(0, 4, 1, 0);
    do_idle(0, 2, 2);
    @(posedge clk);
    #2;
    check_perf("perf_directed");

    for (int n = 0; n < 150; n++) begin
      u  = int'(rbit());
      t  = (u == 1) ? T1 : T0;
      op = int'($urandom_range(0, 9));
      j  = int'($urandom_range(1, t + 3));
      if (op < 4)       do_idle(u, int'($urandom_range(1, 4)), 0);
      else if (op < 9)  do_div(u, j, 0, 0);
      else              do_div(u, j, 0, int'($urandom_range(1, (j < t) ? j : t)));
    end
    do_idle(0, 2, 2);

    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    @(posedge clk);
    #2;
    check_perf("perf_final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter DIV_TIMEOUT, default 40, meaning the maximum number of BUSY cycles before a forced divider abort.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port stallreq_from_id  input  1  load-use bubble request from the decode stage.
REQ-005 SHALL have port div_req  input  1  EX holds a div/divu instruction.
REQ-006 SHALL have port div_ready  input  1  single-cycle pulse from the iterative divider meaning its result is valid.
REQ-007 SHALL have port stall  output  StallBus (6)  per-stage hold: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = Stop.
REQ-008 SHALL have port div_start  output  1  one-cycle pulse that launches the divider.
REQ-009 SHALL have port div_busy  output  1  high while the FSM is in BUSY.
REQ-010 SHALL have port div_timeout  output  1  sticky flag set by an aborted divide.

Function
REQ-011 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-012 IDLE with div_req=1 SHALL pulse div_start in that same cycle and enter BUSY on the next edge.
REQ-013 BUSY with div_ready=1 SHALL enter DONE; otherwise the FSM SHALL stay in BUSY and increment the 6-bit watchdog counter.
REQ-014 BUSY with counter == DIV_TIMEOUT-1 and div_ready=0 SHALL enter DONE and set div_timeout.
REQ-015 When div_ready and the timeout condition coincide, div_ready SHALL take priority and div_timeout SHALL stay clear.
REQ-016 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-017 div_req SHALL be ignored in DONE, because the finishing instruction is still in EX.
REQ-018 div_ready SHALL be ignored in IDLE and in DONE.
REQ-019 The watchdog counter SHALL clear on entry to BUSY.
REQ-020 stall SHALL be combinational from state and inputs, applied in priority order:
  - (IDLE & div_req) | BUSY -> 6'b001111
  - else stallreq_from_id -> 6'b000111
  - else 6'b000000
REQ-021 The EX-stage request SHALL override the ID-stage request in the same cycle, since 001111 is a superset of 000111.
REQ-022 In DONE, stall SHALL be 000000 unless stallreq_from_id=1, in which case it SHALL be 000111.
REQ-023 Back-to-back divides SHALL be legal: the second div_start SHALL occur no earlier than the cycle after DONE.
REQ-024 stall[5:4] SHALL always be 0.

Reset
REQ-025 rst=0 SHALL asynchronously force state=IDLE, counter=0, div_timeout=0, and all perf counters=0.
REQ-026 A reset asserted during BUSY SHALL abandon the divide with no DONE cycle and no further div_start.
REQ-027 While rst=0, stall and div_start SHALL be 0.

Configuration
REQ-028 Macro PIPE_CTRL_PERF_EN SHALL control the performance counters.
  - Defined: add outputs stall_cnt_id[31:0] (cycles with stall==000111) and stall_cnt_ex[31:0] (cycles with stall==001111); both saturate at 32'hFFFF_FFFF.
  - Undefined: neither the ports nor the counter logic exist.

Structure
REQ-029 StallBus, the Stop/NoStop encodings, the two stall patterns, and the FSM state encodings SHALL live in the shared defines package.
REQ-030 The logic SHALL be one module, except for one sub-module div_watchdog containing the 6-bit counter and the timeout compare.

Verification
REQ-031 The bench SHALL cover these scenarios:
  - stallreq_from_id=1 for 1 cycle in IDLE -> stall=000111 in that cycle only; div_start=0.
  - div_req=1 held, div_ready pulsed 10 cycles after start -> div_start in cycle 0; div_busy cycles 1..10; stall=001111 cycles 0..10; DONE in cycle 11 with stall=0.
  - div_req and stallreq_from_id together in IDLE -> stall=001111.
  - DIV_TIMEOUT=8, div_ready never pulsed -> DONE after 8 BUSY cycles; div_timeout=1 until reset.
  - rst=0 in BUSY cycle 3 -> immediate IDLE; stall=0; the next div_req starts cleanly.
  - PIPE_CTRL_PERF_EN defined, 5 load-use cycles then one 4-cycle divide -> stall_cnt_id=5; stall_cnt_ex counts each cycle with stall=001111 (start cycle plus BUSY cycles).
